// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode into ALU operands/op code behind a one-entry valid/ready output register.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + instr, pc, rs1_data, rs2_data upstream;
// flush drops the held entry; out_valid/out_ready downstream with alu_in1, alu_in2, alu_ctrl,
// rd_addr, rd_we, br_en, br_funct3, illegal; issue_count counts completed output transfers.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            br_en,
  output logic [2:0]      br_funct3,
  output logic            illegal,
  output logic [XLEN-1:0] issue_count
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic [3:0]      w_map, w_ctrl;
  logic [XLEN-1:0] w_immi, w_imms, w_immu, w_in1, w_in2;
  logic            w_we, w_br, w_ill, w_accept;
  logic [XLEN-1:0] r_in1, r_in2, r_cnt;
  logic [3:0]      r_ctrl;
  logic [4:0]      r_rd;
  logic [2:0]      r_bf3;
  logic            r_valid, r_we, r_br, r_ill;
  assign w_op   = instr[6:0];
  assign w_rd   = instr[11:7];
  assign w_f3   = instr[14:12];
  assign w_f7   = instr[31:25];
  assign w_immi = {{20{instr[31]}}, instr[31:20]};
  assign w_imms = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_immu = {instr[31:12], 12'b0};
  // funct3 -> op for the funct7=0000000 / OP-IMM family
  assign w_map = w_f3 == 3'd0 ? ADD : w_f3 == 3'd1 ? SLL : w_f3 == 3'd2 ? SLT :
                 w_f3 == 3'd3 ? SLTU : w_f3 == 3'd4 ? XOR : w_f3 == 3'd5 ? SRL :
                 w_f3 == 3'd6 ? OR : AND;
  always_comb begin
    w_in1  = '0;
    w_in2  = '0;
    w_ctrl = ADD;
    w_we   = 1'b0;
    w_br   = 1'b0;
    w_ill  = 1'b0;
    case (w_op)
      7'b0110011: begin
        w_in1  = rs1_data;
        w_in2  = rs2_data;
        w_we   = 1'b1;
        w_ill  = !(w_f7 == 7'd0 || (w_f7 == F7_ALT && (w_f3 == 3'd0 || w_f3 == 3'd5)));
        w_ctrl = w_f7[5] ? (w_f3 == 3'd0 ? SUB : SRA) : w_map;
      end
      7'b0010011: begin
        w_in1  = rs1_data;
        w_in2  = w_immi;
        w_we   = 1'b1;
        w_ill  = (w_f3 == 3'd1 && w_f7 != 7'd0) || (w_f3 == 3'd5 && w_f7 != 7'd0 && w_f7 != F7_ALT);
        w_ctrl = (w_f3 == 3'd5 && instr[30]) ? SRA : w_map;
      end
      7'b0110111: begin
        w_in2 = w_immu;
        w_we  = 1'b1;
      end
      7'b0010111: begin
        w_in1 = pc;
        w_in2 = w_immu;
        w_we  = 1'b1;
      end
      7'b0000011: begin
        w_in1 = rs1_data;
        w_in2 = w_immi;
        w_we  = 1'b1;
      end
      7'b0100011: begin
        w_in1 = rs1_data;
        w_in2 = w_imms;
      end
      7'b1100011: begin
        w_in1  = rs1_data;
        w_in2  = rs2_data;
        w_ctrl = SUB;
        w_br   = 1'b1;
        w_ill  = w_f3 == 3'd2 || w_f3 == 3'd3;
      end
      7'b1101111, 7'b1100111: begin
        w_in1 = pc;
        w_in2 = 32'd4;
        w_we  = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // illegal entries still issue, but carry no operands, no writeback and no branch
    if (w_ill) begin
      w_in1  = '0;
      w_in2  = '0;
      w_ctrl = ADD;
      w_we   = 1'b0;
      w_br   = 1'b0;
    end
    w_we = w_we && w_rd != 5'd0;
  end
  assign in_ready = rst_n && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_br    <= 1'b0;
      r_bf3   <= '0;
      r_ill   <= 1'b0;
    end else begin
      if (r_valid && out_ready && !flush) r_cnt <= r_cnt + 32'd1;
      if (flush) r_valid <= 1'b0;
      else if (w_accept) begin
        r_valid <= 1'b1;
        r_in1   <= w_in1;
        r_in2   <= w_in2;
        r_ctrl  <= w_ctrl;
        r_rd    <= w_rd;
        r_we    <= w_we;
        r_br    <= w_br;
        r_bf3   <= w_br ? w_f3 : 3'd0;
        r_ill   <= w_ill;
      end else if (out_ready) r_valid <= 1'b0;
    end
  end
  assign out_valid   = r_valid;
  assign alu_in1     = r_in1;
  assign alu_in2     = r_in2;
  assign alu_ctrl    = r_ctrl;
  assign rd_addr     = r_rd;
  assign rd_we       = r_we;
  assign br_en       = r_br;
  assign br_funct3   = r_bf3;
  assign illegal     = r_ill;
  assign issue_count = r_cnt;
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-005 SHALL have ports instr input 32, pc input 32, rs1_data input 32 and rs2_data input 32, qualified by in_valid.
REQ-006 SHALL have ports flush input 1, drop held entry, and out_valid output 1 / out_ready input 1, the downstream handshake.
REQ-007 SHALL have ports alu_in1 output 32, alu_in2 output 32 and alu_ctrl output 4, the ALU operands and op code.
REQ-008 SHALL have ports rd_addr output 5, rd_we output 1, br_en output 1, br_funct3 output 3, illegal output 1 and issue_count output 32.

Function
REQ-009 alu_ctrl encoding SHALL be: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
REQ-010 One-entry output register; in_ready = rst_n & (~out_valid | out_ready); accept = in_valid & in_ready.
REQ-011 On accept, decoded fields SHALL be registered, giving out_valid 1 the next cycle; latency 1 cycle.
REQ-012 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-013 out_valid SHALL clear after out_ready=1 without a same-cycle accept; accept and drain together keep out_valid=1 with new data (back-to-back, 1/cycle).
REQ-014 flush=1 SHALL clear out_valid next cycle, override any same-cycle accept, and drop that instruction.
REQ-015 OP (0110011): in1=rs1, in2=rs2; funct7 0000000 with funct3 000..111 -> add,sll,slt,sltu,xor,srl,or,and; funct7 0100000 with funct3 000 -> sub, 101 -> sra.
REQ-016 OP-IMM (0010011): in1=rs1, in2=sign-extended instr[31:20]; funct3 map as OP with 000 always add; 101 with instr[30]=1 -> sra.
REQ-017 LUI: in1=0, in2={instr[31:12],12'b0}, add; AUIPC: same with in1=pc.
REQ-018 LOAD: in1=rs1, in2=sext I-imm, add; STORE: in1=rs1, in2=sext {instr[31:25],instr[11:7]}, add.
REQ-019 BRANCH: in1=rs1, in2=rs2, sub, br_en=1, br_funct3=funct3; for all other opcodes br_en=0 and br_funct3=0.
REQ-020 JAL/JALR: in1=pc, in2=4, add (link value).
REQ-021 illegal=1 SHALL be set for unlisted opcodes, OP funct7 outside {0000000,0100000}, 0100000 with funct3 other than 000/101, OP-IMM shifts with bad funct7, and BRANCH funct3 010/011.
REQ-022 When illegal=1: alu_in1=alu_in2=0, alu_ctrl=0, rd_we=0, br_en=0; entry still presented with out_valid.
REQ-023 rd_addr SHALL be instr[11:7]; rd_we=1 only for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR with rd_addr!=0.
REQ-024 issue_count SHALL increment by 1 on each out_valid & out_ready & ~flush cycle, wrapping 0xFFFFFFFF->0.

Reset
REQ-025 While rst_n=0 at a clk edge: out_valid=0, issue_count=0, all data outputs 0; in_ready=0 while rst_n=0.
REQ-026 Reset mid-operation SHALL discard the held entry; no output transfer counts on the reset cycle.

Verification
REQ-027 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, in1=5, in2=7, ctrl=0, rd_addr=3, rd_we=1.
REQ-028 srai x5,x6,4 (0x40435293), rs1=0x80000000 -> ctrl=7, in2=0x404; illegal=0.
REQ-029 beq x1,x2 with rs1=rs2=9 -> ctrl=1, br_en=1, br_funct3=0, rd_we=0.
REQ-030 out_ready=0 for 3 cycles after issue -> outputs hold, in_ready=0; then out_ready=1 with new in_valid -> back-to-back transfer, issue_count +1.
REQ-031 instr=0xFFFFFFFF -> illegal=1, in1=in2=0, ctrl=0, rd_we=0; flush same cycle as accept -> out_valid=0 next cycle.
REQ-032 issue_count forced to 0xFFFFFFFF then one transfer -> 0; rst_n=0 with out_valid=1 -> out_valid=0, issue_count=0.
